// File: rtl/pcm_stream_fifo.sv
// PCM sample FIFO: CPU pushes 16-bit samples over a simple register bus,
// one sample is popped to the mixer every SAMPLE_DIV clocks while enabled.
module pcm_stream_fifo #(
    parameter int DEPTH      = 512,
    parameter int SAMPLE_DIV = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  addr,
    input  logic [31:0] data_in,
    input  logic        wen,
    input  logic        ren,
    output logic [31:0] data_out,
    output logic        ready,
    output logic [15:0] pcm,
    output logic        irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = (AW + 1 > 13) ? AW + 1 : 13;
    localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    localparam logic [3:0] A_DATA = 4'h0;
    localparam logic [3:0] A_CTRL = 4'h4;
    localparam logic [3:0] A_STAT = 4'h8;

    logic          busy;
    logic          ready_r;
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [LW-1:0] level;
    logic          enable;
    logic [15:0]   thr;
    logic          underrun;
    logic          overflow;
    logic [DW-1:0] div;
    logic [15:0]   mem [DEPTH];

    logic        strobe;
    logic        accept;
    logic        wr;
    logic        rd;
    logic        wr_data;
    logic        wr_ctrl;
    logic        wr_stat;
    logic        flush;
    logic        empty;
    logic        full;
    logic        tick;
    logic        pop;
    logic        push;
    logic        under_set;
    logic        over_set;
    logic [31:0] rd_word;

    assign strobe  = wen | ren;
    assign accept  = strobe & ~busy;
    assign wr      = accept & wen;
    assign rd      = accept & ~wen;
    assign wr_data = wr & (addr == A_DATA);
    assign wr_ctrl = wr & (addr == A_CTRL);
    assign wr_stat = wr & (addr == A_STAT);
    assign flush   = wr_ctrl & data_in[1];

    assign empty = (level == '0);
    assign full  = (level == LW'(DEPTH));
    assign tick  = enable & (div == DW'(SAMPLE_DIV - 1));

    // a pop frees the slot, so a push to a full FIFO on a tick edge fits
    assign pop       = tick & ~empty & ~flush;
    assign push      = wr_data & (~full | pop);
    assign under_set = tick & empty & ~flush;
    assign over_set  = wr_data & full & ~pop;

    assign ready = ready_r & strobe;

    // register read mux
    always_comb begin
        rd_word = '0;
        case (addr)
            A_CTRL:  rd_word = {thr, 14'b0, 1'b0, enable};
            A_STAT:  rd_word = {11'b0, enable, overflow, underrun,
                                full, empty, 16'(level)};
            default: rd_word = '0;
        endcase
    end

    // bus handshake: one access per held strobe, read data captured at accept
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy     <= 1'b0;
            ready_r  <= 1'b0;
            data_out <= '0;
        end else if (accept) begin
            busy    <= 1'b1;
            ready_r <= 1'b1;
            if (rd)
                data_out <= rd_word;
        end else if (!strobe) begin
            busy    <= 1'b0;
            ready_r <= 1'b0;
        end
    end

    // control register and sticky flags; a new event wins over a clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enable   <= 1'b0;
            thr      <= '0;
            underrun <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                enable <= data_in[0];
                thr    <= data_in[31:16];
            end
            underrun <= under_set |
                        (underrun & ~(wr_stat & data_in[18]));
            overflow <= over_set |
                        (overflow & ~(wr_stat & data_in[19]));
        end
    end

    // FIFO pointers and fill level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push)
                wptr <= wptr + AW'(1);
            if (pop)
                rptr <= rptr + AW'(1);
            if (push && !pop)
                level <= level + LW'(1);
            else if (pop && !push)
                level <= level - LW'(1);
        end
    end

    // sample storage, no reset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= data_in[15:0];
    end

    // sample-period divider, parked at zero while disabled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            div <= '0;
        else if (flush || !enable || tick)
            div <= '0;
        else
            div <= div + DW'(1);
    end

    // output sample register: head on tick, silence on underrun/disable
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pcm <= '0;
        else if (flush || !enable)
            pcm <= '0;
        else if (tick)
            pcm <= pop ? mem[rptr] : 16'h0;
    end

    // low-water interrupt, registered from the current level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            irq <= 1'b0;
        else
            irq <= enable & (16'(level) <= thr);
    end

endmodule

// File: tb/tb_pcm_stream_fifo.sv
// Bench for pcm_stream_fifo: register vector table, directed corner
// sequences and random traffic against a queue-based model.
module tb_pcm_stream_fifo;

    localparam int DEPTH = 16;
    localparam int SD    = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  addr = '0;
    logic [31:0] data_in = '0;
    logic        wen = 1'b0;
    logic        ren = 1'b0;
    logic [31:0] data_out;
    logic        ready;
    logic [15:0] pcm;
    logic        irq;

    pcm_stream_fifo #(
        .DEPTH(DEPTH),
        .SAMPLE_DIV(SD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .addr(addr),
        .data_in(data_in),
        .wen(wen),
        .ren(ren),
        .data_out(data_out),
        .ready(ready),
        .pcm(pcm),
        .irq(irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int          n;
    logic [15:0] q[$];
    logic        m_en;
    logic [15:0] m_thr;
    logic        m_und;
    logic        m_ovf;
    logic [15:0] m_pcm;
    logic        m_irq;
    logic        m_busy;
    int          en_edge;
    logic [31:0] rd_exp;
    int          acc_n;

    function automatic logic [31:0] m_word(logic [3:0] a);
        logic [31:0] w;
        w = '0;
        if (a == 4'h4)
            w = {m_thr, 14'b0, 1'b0, m_en};
        else if (a == 4'h8)
            w = {11'b0, m_en, m_ovf, m_und, q.size() == DEPTH,
                 q.size() == 0, 16'(q.size())};
        return w;
    endfunction

    task automatic model_reset();
        q.delete();
        m_en = 0; m_thr = 0; m_und = 0; m_ovf = 0;
        m_pcm = 0; m_irq = 0; m_busy = 0; en_edge = 0;
    endtask

    task automatic model_step();
        bit strobe, acc, w, r, tick, irq_n, old_en;
        n++;
        strobe = wen | ren;
        acc    = strobe & !m_busy;
        w      = acc & wen;
        r      = acc & !wen;
        tick   = m_en && (n > en_edge) && ((n - en_edge) % SD == 0);
        irq_n  = m_en && (q.size() <= int'(m_thr));
        old_en = m_en;
        if (r)
            rd_exp = m_word(addr);
        if (acc) begin
            acc_n  = n;
            m_busy = 1;
        end else if (!strobe) begin
            m_busy = 0;
        end
        if (w && addr == 4'h8) begin
            if (data_in[18]) m_und = 0;
            if (data_in[19]) m_ovf = 0;
        end
        if (w && addr == 4'h4 && data_in[1]) begin
            q.delete();
            m_pcm   = 0;
            m_en    = data_in[0];
            m_thr   = data_in[31:16];
            en_edge = n;
        end else begin
            if (!old_en) begin
                m_pcm = 0;
            end else if (tick) begin
                if (q.size() > 0) begin
                    m_pcm = q.pop_front();
                end else begin
                    m_pcm = 0;
                    m_und = 1;
                end
            end
            if (w && addr == 4'h0) begin
                if (q.size() < DEPTH) q.push_back(data_in[15:0]);
                else m_ovf = 1;
            end
            if (w && addr == 4'h4) begin
                m_en  = data_in[0];
                m_thr = data_in[31:16];
                if (!old_en && m_en) en_edge = n;
            end
        end
        m_irq = irq_n;
    endtask

    initial begin
        n = 0;
        acc_n = 0;
        rd_exp = 0;
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else model_step();
        end
    end

    // continuous output comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            if (rst && chk_on) begin
                check("pcm_track", 32'(pcm), 32'(m_pcm));
                check("irq_track", 32'(irq), 32'(m_irq));
            end
        end
    end

    // ---------------- bus helpers ----------------
    task automatic wait_ready();
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (ready) break;
        end
        check("ready", 32'(ready), 32'd1);
    endtask

    task automatic bus_write(logic [3:0] a, logic [31:0] d);
        @(posedge clk);
        #1;
        addr = a;
        data_in = d;
        wen = 1'b1;
        wait_ready();
        wen = 1'b0;
        #1;
        check("ready_drop", 32'(ready), 32'd0);
    endtask

    task automatic bus_read(logic [3:0] a, output logic [31:0] d);
        @(posedge clk);
        #1;
        addr = a;
        ren = 1'b1;
        wait_ready();
        d = data_out;
        ren = 1'b0;
        #1;
        check("ready_drop", 32'(ready), 32'd0);
    endtask

    task automatic read_model(logic [3:0] a);
        logic [31:0] d;
        bus_read(a, d);
        check("rd_model", d, rd_exp);
    endtask

    task automatic read_const(string name, logic [3:0] a, logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(name, d, exp);
    endtask

    task automatic wait_edge(int t);
        while (n < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    typedef struct {
        logic        w;
        logic [3:0]  a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[12];

    initial begin
        logic [31:0] d;
        int e;
        int r;
        logic [3:0] ra;

        tbl[0]  = '{1'b0, 4'h8, 32'h0, 32'h0001_0000};
        tbl[1]  = '{1'b0, 4'h4, 32'h0, 32'h0000_0000};
        tbl[2]  = '{1'b1, 4'h0, 32'hAAAA_1111, 32'h0};
        tbl[3]  = '{1'b1, 4'h0, 32'h0000_2222, 32'h0};
        tbl[4]  = '{1'b0, 4'h8, 32'h0, 32'h0000_0002};
        tbl[5]  = '{1'b0, 4'h0, 32'h0, 32'h0000_0000};
        tbl[6]  = '{1'b1, 4'h4, 32'h0005_0000, 32'h0};
        tbl[7]  = '{1'b0, 4'h4, 32'h0, 32'h0005_0000};
        tbl[8]  = '{1'b1, 4'h4, 32'h0005_0002, 32'h0};
        tbl[9]  = '{1'b0, 4'h8, 32'h0, 32'h0001_0000};
        tbl[10] = '{1'b0, 4'h4, 32'h0, 32'h0005_0000};
        tbl[11] = '{1'b1, 4'h4, 32'h0000_0000, 32'h0};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_pcm", 32'(pcm), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_dout", data_out, 32'd0);
        rst = 1'b1;
        chk_on = 1'b1;

        // register vector table
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].w) begin
                bus_write(tbl[i].a, tbl[i].d);
            end else begin
                bus_read(tbl[i].a, d);
                check($sformatf("vec%0d", i), d, tbl[i].exp);
            end
        end

        // three samples streamed, then underrun and clear
        bus_write(4'h0, 32'h1111);
        bus_write(4'h0, 32'h2222);
        bus_write(4'h0, 32'h3333);
        bus_write(4'h4, 32'h1);
        e = acc_n;
        wait_edge(e + SD - 1);
        check("t2_pre", 32'(pcm), 32'h0);
        wait_edge(e + SD);
        check("t2_tick1", 32'(pcm), 32'h1111);
        wait_edge(e + 2 * SD);
        check("t2_tick2", 32'(pcm), 32'h2222);
        wait_edge(e + 3 * SD);
        check("t2_tick3", 32'(pcm), 32'h3333);
        wait_edge(e + 4 * SD);
        check("t2_tick4", 32'(pcm), 32'h0);
        read_const("t2_und", 4'h8, 32'h0015_0000);
        bus_write(4'h8, 32'h0004_0000);
        read_const("t2_clr", 4'h8, 32'h0011_0000);
        bus_write(4'h4, 32'h0);

        // overfill while disabled, then drain in order
        bus_write(4'h4, 32'h2);
        for (int i = 0; i < DEPTH + 2; i++)
            bus_write(4'h0, 32'h100 + 32'(i));
        read_const("t3_full", 4'h8, 32'h000A_0010);
        bus_write(4'h4, 32'h1);
        e = acc_n;
        wait_edge(e + SD);
        check("t3_first", 32'(pcm), 32'h100);
        wait_edge(e + DEPTH * SD);
        check("t3_last", 32'(pcm), 32'h100 + 32'(DEPTH - 1));
        bus_write(4'h4, 32'h2);
        bus_write(4'h8, 32'h000C_0000);

        // push into a full FIFO exactly on the pop edge
        for (int i = 0; i < DEPTH; i++)
            bus_write(4'h0, 32'h200 + 32'(i));
        bus_write(4'h4, 32'h1);
        e = acc_n;
        wait_edge(e + SD - 1);
        addr = 4'h0;
        data_in = 32'hBEEF;
        wen = 1'b1;
        wait_ready();
        wen = 1'b0;
        check("t4_pcm", 32'(pcm), 32'h200);
        read_const("t4_stat", 4'h8, 32'h0012_0010);
        bus_write(4'h4, 32'h2);

        // low-water interrupt
        for (int i = 0; i < 6; i++)
            bus_write(4'h0, 32'h300 + 32'(i));
        bus_write(4'h4, 32'h0004_0001);
        e = acc_n;
        wait_edge(e + 3);
        check("t5_irq_hi", 32'(irq), 32'd0);
        wait_edge(e + 2 * SD);
        check("t5_irq_lag", 32'(irq), 32'd0);
        wait_edge(e + 2 * SD + 1);
        check("t5_irq_set", 32'(irq), 32'd1);
        read_const("t5_stat", 4'h8, 32'h0010_0004);

        // flush mid-stream
        wait_edge(e + 3 * SD);
        check("t6_pcm", 32'(pcm), 32'h302);
        bus_write(4'h4, 32'h3);
        check("t6_flush_pcm", 32'(pcm), 32'h0);
        read_const("t6_stat", 4'h8, 32'h0011_0000);

        // reset in the middle of a held write
        @(posedge clk);
        #1;
        addr = 4'h4;
        data_in = 32'h0007_0001;
        wen = 1'b1;
        @(posedge clk);
        #1;
        check("t6_acc", 32'(ready), 32'd1);
        rst = 1'b0;
        #1;
        check("t6_rst_ready", 32'(ready), 32'd0);
        check("t6_rst_dout", data_out, 32'd0);
        check("t6_rst_pcm", 32'(pcm), 32'd0);
        check("t6_rst_irq", 32'(irq), 32'd0);
        wen = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        read_const("t6_post_stat", 4'h8, 32'h0001_0000);
        read_const("t6_post_ctrl", 4'h4, 32'h0);

        // random traffic against the model
        for (int k = 0; k < 400; k++) begin
            repeat ($urandom_range(0, 12)) @(posedge clk);
            r = $urandom_range(0, 99);
            if (r < 45) begin
                bus_write(4'h0, $urandom);
            end else if (r < 60) begin
                ra = 4'($urandom_range(0, 3) * 4);
                read_model(ra);
            end else if (r < 72) begin
                read_model(4'h8);
            end else if (r < 84) begin
                d = {16'($urandom_range(0, DEPTH + 2)), 14'b0,
                     ($urandom_range(0, 9) == 0),
                     ($urandom_range(0, 4) != 0)};
                bus_write(4'h4, d);
            end else if (r < 90) begin
                bus_write(4'h8, $urandom);
            end else begin
                read_model(4'h4);
            end
        end

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
